// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one memory port among NREQ requesters, one transaction at a time.
// Optional WAIT/DRAIN watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_req_arbiter #(
   parameter int NREQ        = 3,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0]          req_we,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_wdata,
   output logic [NREQ-1:0]          req_ready,
   input  logic                     flush,
   output logic                     m_valid,
   output logic                     m_we,
   output logic [ADDR_W-1:0]        m_addr,
   output logic [DATA_W-1:0]        m_wdata,
   input  logic                     m_ready,
   input  logic                     r_valid,
   input  logic [DATA_W-1:0]        r_data,
   input  logic                     r_last,
   output logic [NREQ-1:0]          resp_valid,
   output logic [DATA_W-1:0]        resp_data,
   output logic                     resp_last,
   output logic                     resp_err,
   output logic                     busy
);

   localparam int PTR_W = $clog2(NREQ);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

   state_t           state;
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] owner;
   logic [PTR_W-1:0] grant_idx;
   logic [PTR_W-1:0] next_ptr;
   logic             grant_any;
   logic             to_hit;
   logic [NREQ-1:0]  owner_oh;
   int               scan_idx;

   if (NREQ < 2 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("mem_req_arbiter: NREQ must be >= 2 and TIMEOUT_CYC >= 1");
   end

   // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      scan_idx  = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         scan_idx = (int'(rr_ptr) + k) % NREQ;
         if (req_valid[scan_idx]) begin
            grant_any = 1'b1;
            grant_idx = PTR_W'(scan_idx);
         end
      end
   end

   assign next_ptr  = (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
   assign req_ready = (state == S_IDLE && !flush && grant_any) ? (NREQ'(1) << grant_idx) : '0;
   assign owner_oh  = NREQ'(1) << owner;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] to_cnt;
   assign to_hit   = (state == S_WAIT || state == S_DRAIN) && !r_valid &&
                     (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
   assign resp_err = (state == S_WAIT) && to_hit;
`else
   assign to_hit   = 1'b0;
   assign resp_err = 1'b0;
`endif

   // Response beats pass straight through to the owner; flushed beats are swallowed in DRAIN.
   assign resp_valid = (state == S_WAIT && (r_valid || to_hit)) ? owner_oh : '0;
   assign resp_last  = (state == S_WAIT) && ((r_valid && r_last) || to_hit);
   assign resp_data  = (state == S_WAIT) ? r_data : '0;
   assign busy       = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         rr_ptr  <= '0;
         owner   <= '0;
         m_valid <= 1'b0;
         m_we    <= 1'b0;
         m_addr  <= '0;
         m_wdata <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
         to_cnt  <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (!flush && grant_any) begin
                  owner   <= grant_idx;
                  rr_ptr  <= next_ptr;
                  m_we    <= req_we[grant_idx];
                  m_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                  m_wdata <= req_wdata[grant_idx*DATA_W +: DATA_W];
                  m_valid <= 1'b1;
                  state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  state   <= flush ? S_DRAIN : S_WAIT;
`ifdef MEM_ARB_TIMEOUT_EN
                  to_cnt  <= '0;
`endif
               end else if (flush) begin
                  m_valid <= 1'b0;
                  state   <= S_IDLE;
               end
            end
            S_WAIT: begin
               if ((r_valid && r_last) || to_hit) begin
                  state <= S_IDLE;
               end else if (flush) begin
                  state <= S_DRAIN;
`ifdef MEM_ARB_TIMEOUT_EN
                  to_cnt <= '0;
`endif
               end else begin
`ifdef MEM_ARB_TIMEOUT_EN
                  to_cnt <= r_valid ? '0 : to_cnt + 1'b1;
`endif
               end
            end
            S_DRAIN: begin
               if ((r_valid && r_last) || to_hit) begin
                  state <= S_IDLE;
               end else begin
`ifdef MEM_ARB_TIMEOUT_EN
                  to_cnt <= r_valid ? '0 : to_cnt + 1'b1;
`endif
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level round-robin reference model.
module tb_mem_req_arbiter;

   localparam int NREQ = 3;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int TO   = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_we;
   logic [NREQ*AW-1:0]   req_addr;
   logic [NREQ*DW-1:0]   req_wdata;
   logic [NREQ-1:0]      req_ready;
   logic                 flush;
   logic                 m_valid;
   logic                 m_we;
   logic [AW-1:0]        m_addr;
   logic [DW-1:0]        m_wdata;
   logic                 m_ready;
   logic                 r_valid;
   logic [DW-1:0]        r_data;
   logic                 r_last;
   logic [NREQ-1:0]      resp_valid;
   logic [DW-1:0]        resp_data;
   logic                 resp_last;
   logic                 resp_err;
   logic                 busy;

   int checks   = 0;
   int failures = 0;
   int model_rr = 0;

   logic [AW-1:0] a_arr  [NREQ];
   logic [DW-1:0] d_arr  [NREQ];
   logic          we_arr [NREQ];

   always #5 clk = ~clk;

   mem_req_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .flush(flush),
      .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_ready(m_ready),
      .r_valid(r_valid), .r_data(r_data), .r_last(r_last),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last),
      .resp_err(resp_err), .busy(busy)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "bench timeout");
   end

   // Reference arbitration: first valid requester at or after ptr, wrapping around.
   function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input int g);
      logic [NREQ-1:0] v;
      v = '0;
      if (g >= 0) v[g] = 1'b1;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_reqs(input logic [NREQ-1:0] v, input int we_mode);
      for (int i = 0; i < NREQ; i++) begin
         a_arr[i]  = $urandom;
         d_arr[i]  = $urandom;
         we_arr[i] = (we_mode == 2) ? 1'($urandom_range(0, 1)) : (we_mode == 1);
         req_addr[i*AW +: AW]  = a_arr[i];
         req_wdata[i*DW +: DW] = d_arr[i];
         req_we[i]             = we_arr[i];
      end
      req_valid = v;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      flush = 1'b0; m_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_last = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      model_rr = 0;
      tick();
   endtask

   task automatic run_txn(input logic [NREQ-1:0] vmask, input int we_mode, input int stall,
                          input int nbeats, output int g_obs);
      int g, s, nb, gap;
      logic [DW-1:0] beat;
      set_reqs(vmask, we_mode);
      #1;
      g = pick(vmask, model_rr);
      g_obs = -1;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) g_obs = i;
      checks++;
      if (req_ready !== onehot(g)) begin
         failures++;
         $display("FAIL grant req_ready got=%b exp=%b", req_ready, onehot(g));
      end
      if (g < 0) begin
         tick();
         return;
      end
      tick();
      model_rr = (g + 1) % NREQ;
      s = (stall < 0) ? $urandom_range(0, 3) : stall;
      for (int c = 0; c <= s; c++) begin
         m_ready = (c == s);
         #1;
         checks++;
         if (m_valid !== 1'b1 || m_addr !== a_arr[g] || m_we !== we_arr[g] ||
             (we_arr[g] && m_wdata !== d_arr[g]) || req_ready !== '0) begin
            failures++;
            $display("FAIL issue got v=%b a=%h we=%b d=%h rdy=%b exp v=1 a=%h we=%b d=%h rdy=0",
                     m_valid, m_addr, m_we, m_wdata, req_ready, a_arr[g], we_arr[g], d_arr[g]);
         end
         tick();
      end
      m_ready = 1'b0;
      nb = we_arr[g] ? 1 : ((nbeats > 0) ? nbeats : $urandom_range(1, 4));
      for (int b = 0; b < nb; b++) begin
         gap = $urandom_range(0, 2);
         for (int q = 0; q < gap; q++) begin
            r_valid = 1'b0;
            #1;
            checks++;
            if (resp_valid !== '0 || busy !== 1'b1 || m_valid !== 1'b0) begin
               failures++;
               $display("FAIL wait_gap got resp_valid=%b busy=%b m_valid=%b exp 0/1/0",
                        resp_valid, busy, m_valid);
            end
            tick();
         end
         beat = $urandom;
         r_valid = 1'b1; r_data = beat; r_last = (b == nb - 1);
         #1;
         checks++;
         if (resp_valid !== onehot(g) || resp_data !== beat || resp_last !== (b == nb - 1) ||
             req_ready !== '0) begin
            failures++;
            $display("FAIL beat got v=%b d=%h l=%b rdy=%b exp v=%b d=%h l=%b rdy=0",
                     resp_valid, resp_data, resp_last, req_ready, onehot(g), beat, (b == nb - 1));
         end
         tick();
         r_valid = 1'b0; r_last = 1'b0;
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL txn_end busy got=%b exp=0", busy);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      flush = 1'b0; m_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_last = 1'b0;
      #3;
      checks++;
      if (req_ready !== '0 || m_valid !== 1'b0 || resp_valid !== '0 || resp_last !== 1'b0 ||
          resp_err !== 1'b0 || busy !== 1'b0 || m_addr !== '0) begin
         failures++;
         $display("FAIL reset_state got rdy=%b mv=%b rv=%b rl=%b re=%b busy=%b addr=%h exp all 0",
                  req_ready, m_valid, resp_valid, resp_last, resp_err, busy, m_addr);
      end
      tick();
      rst = 1'b1;
      tick();
      r_valid = 1'b1; r_last = 1'b1; r_data = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (resp_valid !== '0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_stray_beat got resp_valid=%b busy=%b exp 0/0", resp_valid, busy);
      end
      tick();
      r_valid = 1'b0; r_last = 1'b0;
      req_valid = 3'b001;
      tick();
      req_valid = '0;
      rst = 1'b0;
      #1;
      checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL async_reset got m_valid=%b busy=%b exp 0/0", m_valid, busy);
      end
      tick();
      rst = 1'b1;
      model_rr = 0;
      tick();
   endtask

   task automatic test_single_read();
      logic [DW-1:0] beats [4];
      beats = '{32'hA, 32'hB, 32'hC, 32'hD};
      do_reset();
      req_valid = 3'b001; req_we = '0; req_addr = '0; req_addr[AW-1:0] = 32'h1000;
      #1;
      checks++;
      if (req_ready !== 3'b001 || m_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_grant got rdy=%b mv=%b exp 001/0", req_ready, m_valid);
      end
      tick();
      req_valid = '0;
      m_ready = 1'b1;
      #1;
      checks++;
      if (m_valid !== 1'b1 || m_addr !== 32'h1000 || m_we !== 1'b0) begin
         failures++;
         $display("FAIL single_issue got mv=%b addr=%h we=%b exp 1/1000/0", m_valid, m_addr, m_we);
      end
      tick();
      m_ready = 1'b0;
      for (int b = 0; b < 4; b++) begin
         r_valid = 1'b1; r_data = beats[b]; r_last = (b == 3);
         #1;
         checks++;
         if (resp_valid !== 3'b001 || resp_data !== beats[b] || resp_last !== (b == 3)) begin
            failures++;
            $display("FAIL single_beat%0d got v=%b d=%h l=%b exp v=001 d=%h l=%b",
                     b, resp_valid, resp_data, resp_last, beats[b], (b == 3));
         end
         tick();
      end
      r_valid = 1'b0; r_last = 1'b0;
      model_rr = 1;
   endtask

   task automatic test_round_robin();
      int exp_order [4];
      int g;
      exp_order = '{0, 1, 2, 0};
      do_reset();
      for (int t = 0; t < 4; t++) begin
         run_txn(3'b111, 1, 0, 1, g);
         checks++;
         if (g !== exp_order[t]) begin
            failures++;
            $display("FAIL rr_order%0d got=%0d exp=%0d", t, g, exp_order[t]);
         end
      end
   endtask

   task automatic test_backpressure();
      int g;
      run_txn(3'b111, 2, 5, 0, g);
      run_txn(3'b101, 2, 5, 0, g);
   endtask

   task automatic test_random();
      int g;
      do_reset();
      for (int t = 0; t < 40; t++) begin
         run_txn(NREQ'($urandom_range(0, 7)), 2, -1, 0, g);
      end
   endtask

   task automatic test_flush_wait();
      int g;
      g = pick(3'b010, model_rr);
      req_valid = 3'b010; req_we = '0;
      #1;
      tick();
      req_valid = '0;
      model_rr = (g + 1) % NREQ;
      m_ready = 1'b1;
      #1;
      tick();
      m_ready = 1'b0;
      r_valid = 1'b1; r_data = 32'h11; r_last = 1'b0;
      #1;
      checks++;
      if (resp_valid !== onehot(g)) begin
         failures++;
         $display("FAIL flush_wait_first got=%b exp=%b", resp_valid, onehot(g));
      end
      tick();
      r_valid = 1'b0; flush = 1'b1;
      #1;
      tick();
      flush = 1'b0;
      for (int b = 0; b < 3; b++) begin
         r_valid = 1'b1; r_data = 32'h20 + b; r_last = (b == 2);
         #1;
         checks++;
         if (resp_valid !== '0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL drain_beat%0d got v=%b busy=%b exp 000/1", b, resp_valid, busy);
         end
         tick();
      end
      r_valid = 1'b0; r_last = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL drain_end busy got=%b exp=0", busy);
      end
      req_valid = 3'b001;
      #1;
      checks++;
      if (req_ready !== onehot(pick(3'b001, model_rr))) begin
         failures++;
         $display("FAIL post_drain_grant got=%b exp=%b", req_ready, onehot(pick(3'b001, model_rr)));
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_flush_issue();
      int g;
      req_valid = 3'b001; flush = 1'b1;
      #1;
      checks++;
      if (req_ready !== '0) begin
         failures++;
         $display("FAIL flush_idle got=%b exp=000", req_ready);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL flush_idle_busy got=%b exp=0", busy);
      end
      flush = 1'b0;
      g = pick(3'b001, model_rr);
      #1;
      tick();
      req_valid = '0;
      model_rr = (g + 1) % NREQ;
      m_ready = 1'b0; flush = 1'b1;
      #1;
      checks++;
      if (m_valid !== 1'b1) begin
         failures++;
         $display("FAIL flush_issue_pre got m_valid=%b exp=1", m_valid);
      end
      tick();
      flush = 1'b0;
      checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL flush_issue_post got mv=%b busy=%b exp 0/0", m_valid, busy);
      end
      req_valid = 3'b111;
      #1;
      checks++;
      if (req_ready !== onehot(model_rr)) begin
         failures++;
         $display("FAIL flush_issue_rr got=%b exp=%b", req_ready, onehot(model_rr));
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_timeout();
      int g;
      g = pick(3'b100, model_rr);
      req_valid = 3'b100; req_we = '0;
      #1;
      tick();
      req_valid = '0;
      model_rr = (g + 1) % NREQ;
      m_ready = 1'b1;
      #1;
      tick();
      m_ready = 1'b0;
      for (int k = 1; k < TO; k++) begin
         #1;
         checks++;
         if (resp_valid !== '0 || busy !== 1'b1 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL wait_cycle%0d got v=%b busy=%b err=%b exp 000/1/0", k, resp_valid, busy, resp_err);
         end
         tick();
      end
      #1;
`ifdef MEM_ARB_TIMEOUT_EN
      checks++;
      if (resp_valid !== onehot(g) || resp_last !== 1'b1 || resp_err !== 1'b1) begin
         failures++;
         $display("FAIL timeout_pulse got v=%b l=%b err=%b exp v=%b l=1 err=1",
                  resp_valid, resp_last, resp_err, onehot(g));
      end
      tick();
      checks++;
      if (busy !== 1'b0 || resp_valid !== '0) begin
         failures++;
         $display("FAIL timeout_idle got busy=%b v=%b exp 0/000", busy, resp_valid);
      end
`else
      checks++;
      if (resp_valid !== '0 || resp_err !== 1'b0) begin
         failures++;
         $display("FAIL no_timeout got v=%b err=%b exp 000/0", resp_valid, resp_err);
      end
      tick();
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (busy !== 1'b1) begin
            failures++;
            $display("FAIL wait_forever busy got=%b exp=1", busy);
         end
         tick();
      end
      r_valid = 1'b1; r_last = 1'b1; r_data = 32'h5A5A;
      #1;
      checks++;
      if (resp_valid !== onehot(g) || resp_last !== 1'b1) begin
         failures++;
         $display("FAIL late_beat got v=%b l=%b exp v=%b l=1", resp_valid, resp_last, onehot(g));
      end
      tick();
      r_valid = 1'b0; r_last = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL late_beat_idle busy got=%b exp=0", busy);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_backpressure();
      test_flush_wait();
      test_flush_issue();
      test_timeout();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
